// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage controller that turns LW/SW into a req/ack
// transaction on the data-memory port. It stalls the pipeline until the
// access completes, and a timeout forces completion with an error flag.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 15,
    parameter logic [15:0] ERR_DATA       = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    // EX/MEM side
    input  logic        Mem_Read_In,
    input  logic        Mem_Write_In,
    input  logic [15:0] ALU_Result_In,
    input  logic [15:0] Write_Data_In,
    input  logic        Reg_Write_In,
    input  logic [1:0]  Mem_To_Reg_In,
    input  logic [15:0] PC_Adder_In,
    input  logic [2:0]  Write_Reg_In,
    // MEM/WB side
    output logic        Reg_Write_Out,
    output logic [1:0]  Mem_To_Reg_Out,
    output logic [15:0] PC_Adder_Out,
    output logic [15:0] ALU_Result_Out,
    output logic [2:0]  Write_Reg_Out,
    output logic [15:0] Read_Data_Out,
    output logic        Mem_Stall,
    // data-memory port
    output logic        Dmem_Req,
    output logic        Dmem_We,
    output logic [15:0] Dmem_Addr,
    output logic [15:0] Dmem_Wdata,
    input  logic [15:0] Dmem_Rdata,
    input  logic        Dmem_Ack,
    output logic        Mem_Error
);

    // Counter only needs to reach TIMEOUT_CYCLES-1, so it never wraps.
    localparam int unsigned    CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               req_q,   req_d;
    logic               we_q,    we_d;
    logic [15:0]        addr_q,  addr_d;
    logic [15:0]        wdata_q, wdata_d;
    logic [15:0]        rdata_q, rdata_d;
    logic               err_q,   err_d;
    logic               access_s;

    // A write wins when both read and write are flagged.
    assign access_s = Mem_Read_In | Mem_Write_In;

    // Pass-through of pipeline fields to MEM/WB with no latency.
    assign Reg_Write_Out  = Reg_Write_In;
    assign Mem_To_Reg_Out = Mem_To_Reg_In;
    assign PC_Adder_Out   = PC_Adder_In;
    assign ALU_Result_Out = ALU_Result_In;
    assign Write_Reg_Out  = Write_Reg_In;

    // Stall is low in DONE so the pipeline advances on the edge leaving it.
    assign Mem_Stall = ((state_q == ST_IDLE) && access_s) || (state_q == ST_WAIT);

    assign Dmem_Req      = req_q;
    assign Dmem_We       = we_q;
    assign Dmem_Addr     = addr_q;
    assign Dmem_Wdata    = wdata_q;
    assign Read_Data_Out = rdata_q;
    assign Mem_Error     = err_q;

    // Next-state and next-register computation for the access FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (access_s) begin
                    we_d    = Mem_Write_In;
                    addr_d  = ALU_Result_In;
                    wdata_d = Write_Data_In;
                    req_d   = 1'b1;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (Dmem_Ack) begin
                    if (!we_q) begin
                        rdata_d = Dmem_Rdata;
                    end else begin
                        rdata_d = rdata_q;
                    end
                    req_d   = 1'b0;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    if (!we_q) begin
                        rdata_d = ERR_DATA;
                    end else begin
                        rdata_d = rdata_q;
                    end
                    err_d   = 1'b1;
                    req_d   = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any request in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            rdata_q <= 16'h0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule
